// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and the bit-counter width helper
// for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: one-bit full subtractor built from two half subtractors.
// Ports:
//   x    - minuend bit
//   y    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit, x - y - bin
//   bout - borrow out
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1, b1, b2;

    assign d1   = x ^ y;
    assign b1   = ~x & y;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock, start/done handshake.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - request pulse, only honoured in IDLE
//   a, b       - minuend / subtrahend, captured when start is accepted
//   busy       - high while bits are being shifted
//   done       - one-cycle pulse when diff/borrow_out have been updated
//   diff       - (a - b) mod 2^WIDTH, held until the next operation completes
//   borrow_out - 1 iff a < b (unsigned), held with diff
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sres_q, sres_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bff_q, bff_d, bo_q, bo_d;
    logic             d, bout;
    logic [WIDTH:0]   sres_cat;

    full_subtractor_cell u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bff_q),
        .d    (d),
        .bout (bout)
    );

    // New bit enters at the MSB; dropping bit 0 of the concatenation also works for WIDTH=1.
    assign sres_cat = {d, sres_q};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sres_d  = sres_q;
        cnt_d   = cnt_q;
        bff_d   = bff_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
        if (state_q == IDLE) begin
            if (start) begin
                sa_d    = a;
                sb_d    = b;
                sres_d  = '0;
                cnt_d   = '0;
                bff_d   = 1'b0;
                state_d = SHIFT;
            end
        end else if (state_q == SHIFT) begin
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            sres_d = sres_cat[WIDTH:1];
            bff_d  = bout;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                diff_d  = sres_cat[WIDTH:1];
                bo_d    = bout;
                state_d = DONE;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sres_q  <= '0;
            cnt_q   <= '0;
            bff_q   <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sres_q  <= sres_d;
            cnt_q   <= cnt_d;
            bff_q   <= bff_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and scoreboarded checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start1;
    logic [7:0] a, b, diff;
    logic [0:0] a1, b1, diff1;
    logic       busy, done, borrow_out, busy1, done1, bo1;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] held_d;
    logic       held_b;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One WIDTH=8 operation; start goes up at a negedge and is accepted at the next posedge.
    // With hold set, start stays high and the operands change mid-shift.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] ed, input logic eb, input bit hold);
        @(negedge clk);
        check("done_once", done, 0);
        check("idle_busy", busy, 0);
        start = 1'b1;
        a     = ia;
        b     = ib;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (hold && i == 3) begin
                a = 8'h00;
                b = 8'hFF;
            end
            if (i < 8) begin
                check("busy", busy, 1);
                check("no_done", done, 0);
                check("diff_held", diff, held_d);
                check("bo_held", borrow_out, held_b);
            end else begin
                check("done", done, 1);
                check("busy_off", busy, 0);
                check("diff", diff, ed);
                check("borrow", borrow_out, eb);
                start = 1'b0;
            end
        end
        held_d = ed;
        held_b = eb;
    endtask

    task automatic op1(input logic ia, input logic ib, input logic ed, input logic eb);
        @(negedge clk);
        check("w1_idle", busy1, 0);
        start1 = 1'b1;
        a1     = ia;
        b1     = ib;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", busy1, 1);
        check("w1_no_done", done1, 0);
        @(negedge clk);
        check("w1_done", done1, 1);
        check("w1_diff", diff1, ed);
        check("w1_borrow", bo1, eb);
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        a      = '0;
        b      = '0;
        a1     = '0;
        b1     = '0;
        held_d = '0;
        held_b = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        op8(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // Abandon an operation with an asynchronous reset in its fourth shift cycle.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h23;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_diff", diff, 0);
        check("arst_borrow", borrow_out, 0);
        held_d = '0;
        held_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
        end
        op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

        op1(1'b0, 1'b0, 1'b0, 1'b0);
        op1(1'b0, 1'b1, 1'b1, 1'b1);
        op1(1'b1, 1'b0, 1'b1, 1'b0);
        op1(1'b1, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op8(ra, rb, ra - rb, ra < rb, 1'b0);
        end
        @(negedge clk);
        check("final_done_once", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
